// File: rtl/mealy_sched_pkg.sv
// Shared types for the round-robin Mealy stream scheduler.
// Scheduler states, core states and the 2-bit core output codes.
package mealy_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } sched_state_t;

    typedef enum logic [1:0] {
        S0,
        S1,
        S2,
        S3
    } core_state_t;

    localparam logic [1:0] C00 = 2'b00;
    localparam logic [1:0] C01 = 2'b01;
    localparam logic [1:0] C10 = 2'b10;
    localparam logic [1:0] C11 = 2'b11;

endpackage

// File: rtl/mealy4_core.sv
// 4-state Mealy sequence core: registered state, sync clear,
// combinational output from current state and input bit.
module mealy4_core
    import mealy_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       data_in,
    output logic [1:0] data_out
);

    core_state_t st;
    core_state_t nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st <= S0;
        end else if (clr) begin
            st <= S0;
        end else begin
            st <= nxt;
        end
    end

    always_comb begin
        nxt      = st;
        data_out = C00;
        unique case (st)
            S0: begin
                nxt      = S1;
                data_out = data_in ? C00 : C10;
            end
            S1: begin
                nxt      = data_in ? S2 : S1;
                data_out = data_in ? C01 : C00;
            end
            S2: begin
                nxt      = data_in ? S3 : S1;
                data_out = data_in ? C10 : C01;
            end
            S3: begin
                nxt      = data_in ? S2 : S3;
                data_out = data_in ? C11 : C00;
            end
        endcase
    end

endmodule

// File: rtl/mealy_stream_sched.sv
// Round-robin scheduler sharing one mealy4_core between requesters;
// serialises each granted word MSB-first and returns packed codes.
module mealy_stream_sched
    import mealy_sched_pkg::*;
#(
    parameter  int NREQ   = 4,
    parameter  int WORD_W = 8,
    localparam int IDW    = $clog2(NREQ),
    localparam int CW     = $clog2(WORD_W + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*WORD_W-1:0] req_word,
    output logic [NREQ-1:0]        gnt,
    output logic                   busy,
    output logic                   done,
    output logic [IDW-1:0]         done_id,
    output logic [2*WORD_W-1:0]    result,
    output logic [CW-1:0]          cnt3
);

    sched_state_t          state;
    logic [WORD_W-1:0]     shreg;
    logic [CW-1:0]         bitcnt;
    logic [CW-1:0]         acc_cnt;
    logic [2*WORD_W-1:0]   acc;
    logic [IDW-1:0]        last_id;
    logic [IDW-1:0]        winner;
    logic [IDW-1:0]        pick;
    logic                  found;
    logic [IDW:0]          sum;
    logic                  core_clr;
    logic [1:0]            code;
    logic [2*WORD_W-1:0]   acc_nxt;
    logic [CW-1:0]         cnt_nxt;

    // Core sits at S0 outside SHIFT, so it is clear on the grant edge.
    assign core_clr = (state != SHIFT);

    mealy4_core u_core (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (core_clr),
        .data_in  (shreg[WORD_W-1]),
        .data_out (code)
    );

    assign acc_nxt = {acc[2*WORD_W-3:0], code};
    assign cnt_nxt = acc_cnt + CW'(code == C11);

    // First asserted req searching upward from last_id+1, with wrap.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            sum = {1'b0, last_id} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            if (!found && req[sum[IDW-1:0]]) begin
                found = 1'b1;
                pick  = sum[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            gnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= '0;
            result  <= '0;
            cnt3    <= '0;
            last_id <= IDW'(NREQ - 1);
            winner  <= '0;
            shreg   <= '0;
            bitcnt  <= '0;
            acc     <= '0;
            acc_cnt <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        gnt     <= NREQ'(1) << pick;
                        busy    <= 1'b1;
                        winner  <= pick;
                        shreg   <= req_word[int'(pick)*WORD_W +: WORD_W];
                        bitcnt  <= '0;
                        acc     <= '0;
                        acc_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg   <= shreg << 1;
                    bitcnt  <= bitcnt + CW'(1);
                    acc     <= acc_nxt;
                    acc_cnt <= cnt_nxt;
                    if (bitcnt == CW'(WORD_W - 1)) begin
                        gnt     <= '0;
                        done    <= 1'b1;
                        done_id <= winner;
                        result  <= acc_nxt;
                        cnt3    <= cnt_nxt;
                        last_id <= winner;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mealy_stream_sched.sv
// Directed plus randomized bench for mealy_stream_sched against a
// word-level reference of the Mealy core and round-robin order.
module tb_mealy_stream_sched;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;
    localparam int CW  = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_word;
    logic [N-1:0]     gnt;
    logic             busy;
    logic             done;
    logic [IDW-1:0]   done_id;
    logic [2*W-1:0]   result;
    logic [CW-1:0]    cnt3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mealy_stream_sched #(.NREQ(N), .WORD_W(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_word (req_word),
        .gnt      (gnt),
        .busy     (busy),
        .done     (done),
        .done_id  (done_id),
        .result   (result),
        .cnt3     (cnt3)
    );

    // Walk the word MSB-first through the state/output table.
    function automatic logic [2*W-1:0] ref_result(input logic [W-1:0] w);
        int s;
        int b;
        int c;
        logic [2*W-1:0] r;
        s = 0;
        r = '0;
        for (int i = W - 1; i >= 0; i--) begin
            b = int'(w[i]);
            c = 0;
            case (s)
                0: begin c = b ? 0 : 2; s = 1; end
                1: begin c = b ? 1 : 0; s = b ? 2 : 1; end
                2: begin c = b ? 2 : 1; s = b ? 3 : 1; end
                default: begin c = b ? 3 : 0; s = b ? 2 : 3; end
            endcase
            r = (r << 2) | (2*W)'(c);
        end
        return r;
    endfunction

    function automatic int ref_cnt3(input logic [2*W-1:0] r);
        int n;
        n = 0;
        for (int i = 0; i < W; i++) begin
            if (r[2*i +: 2] == 2'b11) n++;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, output int cyc);
        bit ok;
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(ok), 32'd1);
    endtask

    // One isolated job with exact cycle-by-cycle timing checks.
    task automatic do_single(input int id, input logic [W-1:0] w,
                             input string tag);
        logic [2*W-1:0] er;
        logic [N-1:0]   eg;
        bit             held;
        er = ref_result(w);
        eg = N'(1) << id;
        req_word[id*W +: W] = w;
        req = eg;
        @(negedge clk);
        check({tag, "_gnt"}, 32'(gnt), 32'(eg));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        req      = '0;
        req_word = $urandom;
        held     = 1'b1;
        for (int i = 1; i < W; i++) begin
            @(negedge clk);
            held &= (gnt === eg) && (done === 1'b0);
        end
        check({tag, "_gnt_held"}, 32'(held), 32'd1);
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_done_id"}, 32'(done_id), 32'(id));
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_cnt3"}, 32'(cnt3), 32'(ref_cnt3(er)));
        check({tag, "_gnt_off"}, 32'(gnt), 32'd0);
        @(negedge clk);
        check({tag, "_done_low"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_hold"}, 32'(result), 32'(er));
    endtask

    initial begin
        int             cyc;
        int             ptr;
        int             exp_id;
        bit             saw;
        logic [W-1:0]   words [N];
        logic [W-1:0]   w0;
        logic [W-1:0]   w2;
        logic [W-1:0]   w3;

        reset_n  = 1'b0;
        req      = '0;
        req_word = '0;
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_id", 32'(done_id), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cnt3", 32'(cnt3), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        do_single(0, 8'hFF, "ff");
        check("ff_lit_result", 32'(result), 32'h1BBB);
        check("ff_lit_cnt3", 32'(cnt3), 32'd3);
        do_single(0, 8'h00, "zero");
        check("zero_lit_result", 32'(result), 32'h8000);
        check("zero_lit_cnt3", 32'(cnt3), 32'd0);

        repeat (6) do_single(int'($urandom_range(0, N - 1)), W'($urandom), "rnd");

        do_single(1, W'($urandom), "pulse1");

        // All requesters held: rotation order and job period.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            words[i] = W'((($urandom & 32'h3F) | (i << 6)));
            req_word[i*W +: W] = words[i];
        end
        req = '1;
        ptr = N - 1;
        for (int j = 0; j < 5; j++) begin
            exp_id = (ptr + 1) % N;
            ptr    = exp_id;
            wait_done("rr", cyc);
            check("rr_done_id", 32'(done_id), 32'(exp_id));
            check("rr_result", 32'(result), 32'(ref_result(words[exp_id])));
            check("rr_cnt3", 32'(cnt3),
                  32'(ref_cnt3(ref_result(words[exp_id]))));
            check("rr_period", 32'(cyc), (j == 0) ? 32'(W + 1) : 32'(W + 2));
        end
        req = '0;
        repeat (2) @(negedge clk);
        check("rr_quiet_busy", 32'(busy), 32'd0);
        check("rr_quiet_gnt", 32'(gnt), 32'd0);

        // Late request from 2 waits for the running job of 0.
        w0 = W'($urandom);
        w2 = W'($urandom);
        req_word[0 +: W] = w0;
        req = 4'b0001;
        @(negedge clk);
        check("late_gnt0", 32'(gnt), 32'h1);
        req = '0;
        repeat (2) @(negedge clk);
        req_word[2*W +: W] = w2;
        req = 4'b0100;
        saw = 1'b0;
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt[2] === 1'b1) saw = 1'b1;
            if (done === 1'b1) begin
                cyc = 1;
                break;
            end
        end
        check("late_done_seen", 32'(cyc), 32'd1);
        check("late_no_preempt", 32'(saw), 32'd0);
        check("late_done_id0", 32'(done_id), 32'd0);
        check("late_result0", 32'(result), 32'(ref_result(w0)));
        @(negedge clk);
        check("late_idle_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        check("late_gnt2", 32'(gnt), 32'h4);
        req = '0;
        wait_done("late2", cyc);
        check("late_done_id2", 32'(done_id), 32'd2);
        check("late_result2", 32'(result), 32'(ref_result(w2)));

        // Reset in the middle of a job drops it without a done pulse.
        repeat (2) @(negedge clk);
        w3 = W'($urandom);
        req_word[3*W +: W] = w3;
        req = 4'b1000;
        @(negedge clk);
        check("abort_gnt3", 32'(gnt), 32'h8);
        req = '0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_gnt", 32'(gnt), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_done_id", 32'(done_id), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_cnt3", 32'(cnt3), 32'd0);
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw = 1'b1;
        end
        reset_n = 1'b1;
        repeat (W + 3) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw = 1'b1;
        end
        check("abort_no_done", 32'(saw), 32'd0);
        do_single(3, w3, "rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
